// File: rtl/time_counter.sv
// Hours/minutes/seconds BCD time counter with RUN / SET_HOUR / SET_MIN key control.
// Define TIME_COUNTER_HOUR12_EN for 12-hour display with a PM flag; the default is 24-hour.
module time_counter #(
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       CLK_50M,
    input  logic       CLR,
    input  logic       CLK_1HzIn,
    input  logic       MODE_Key,
    input  logic       INC_Key,
    output logic [3:0] Sec_L,
    output logic [3:0] Sec_H,
    output logic [3:0] Min_L,
    output logic [3:0] Min_H,
    output logic [3:0] Hour_L,
    output logic [3:0] Hour_H,
    output logic [1:0] Mode_State,
    output logic       Sec_Tick,
    output logic       Day_Carry,
    output logic       PM
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

`ifdef TIME_COUNTER_HOUR12_EN
    localparam int   INIT_HDISP = (INIT_HOUR % 12 == 0) ? 12 : INIT_HOUR % 12;
    localparam logic INIT_PM    = (INIT_HOUR >= 12);
`else
    localparam int   INIT_HDISP = INIT_HOUR;
    localparam logic INIT_PM    = 1'b0;
`endif
    localparam logic [7:0] INIT_HOUR_BCD = {4'(INIT_HDISP / 10), 4'(INIT_HDISP % 10)};
    localparam logic [7:0] INIT_MIN_BCD  = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10)};

    mode_t      r_mode;
    logic [7:0] r_sec, r_min, r_hour;
    logic       r_sec_tick, r_day_carry, r_pm;
    logic       r_prev_1hz, r_prev_mode, r_prev_inc;
    logic       r_armed;
    logic       w_tick, w_mode_ev, w_inc_ev;

    // r_armed masks the first sample after reset, so a level already high at release is not an edge.
    assign w_tick    = CLK_1HzIn & ~r_prev_1hz  & r_armed;
    assign w_mode_ev = MODE_Key  & ~r_prev_mode & r_armed;
    assign w_inc_ev  = INC_Key   & ~r_prev_inc  & r_armed;

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
`ifdef TIME_COUNTER_HOUR12_EN
        if (v == 8'h12) return 8'h01;
        if (v == 8'h09) return 8'h10;
`else
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
`endif
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // NOTE: every register below is assigned with <= so all of them sample pre-edge values.
    always_ff @(posedge CLK_50M or posedge CLR) begin
        if (CLR) begin
            r_mode      <= RUN;
            r_sec       <= 8'h00;
            r_min       <= INIT_MIN_BCD;
            r_hour      <= INIT_HOUR_BCD;
            r_pm        <= INIT_PM;
            r_sec_tick  <= 1'b0;
            r_day_carry <= 1'b0;
            r_prev_1hz  <= 1'b0;
            r_prev_mode <= 1'b0;
            r_prev_inc  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_prev_1hz  <= CLK_1HzIn;
            r_prev_mode <= MODE_Key;
            r_prev_inc  <= INC_Key;
            r_armed     <= 1'b1;
            r_sec_tick  <= 1'b0;
            r_day_carry <= 1'b0;

            // A tick landing on the RUN->SET_HOUR step is still counted.
            if (r_mode == RUN && w_tick) begin
                r_sec_tick <= 1'b1;
                r_sec      <= inc_mod60(r_sec);
                if (r_sec == 8'h59) begin
                    r_min <= inc_mod60(r_min);
                    if (r_min == 8'h59) begin
                        r_hour <= inc_hour(r_hour);
`ifdef TIME_COUNTER_HOUR12_EN
                        if (r_hour == 8'h11) begin
                            r_pm        <= ~r_pm;
                            r_day_carry <= r_pm;
                        end
`else
                        r_day_carry <= (r_hour == 8'h23);
`endif
                    end
                end
            end

            if (w_mode_ev) begin
                case (r_mode)
                    RUN:      r_mode <= SET_HOUR;
                    SET_HOUR: r_mode <= SET_MIN;
                    default: begin
                        r_mode <= RUN;
                        r_sec  <= 8'h00;
                    end
                endcase
            end else if (w_inc_ev) begin
                if (r_mode == SET_HOUR) begin
                    r_hour <= inc_hour(r_hour);
`ifdef TIME_COUNTER_HOUR12_EN
                    if (r_hour == 8'h11) r_pm <= ~r_pm;
`endif
                end else if (r_mode == SET_MIN) begin
                    r_min <= inc_mod60(r_min);
                end
            end
        end
    end

    assign Sec_L      = r_sec[3:0];
    assign Sec_H      = r_sec[7:4];
    assign Min_L      = r_min[3:0];
    assign Min_H      = r_min[7:4];
    assign Hour_L     = r_hour[3:0];
    assign Hour_H     = r_hour[7:4];
    assign Mode_State = r_mode;
    assign Sec_Tick   = r_sec_tick;
    assign Day_Carry  = r_day_carry;
    assign PM         = r_pm;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios then random stimulus against a seconds-of-day model.
// Build with TIME_COUNTER_HOUR12_EN defined to check the 12-hour variant.
module tb_time_counter;

    localparam int INIT_H = 23;
    localparam int INIT_M = 59;

    logic       CLK_50M, CLR, CLK_1HzIn, MODE_Key, INC_Key;
    logic [3:0] Sec_L, Sec_H, Min_L, Min_H, Hour_L, Hour_H;
    logic [1:0] Mode_State;
    logic       Sec_Tick, Day_Carry, PM;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time as seconds since midnight, mode 0/1/2.
    int m_secs;
    int m_mode;
    bit m_prev_hz, m_prev_mk, m_prev_ik, m_armed;
    bit e_tick, e_dc;

    time_counter #(.INIT_HOUR(INIT_H), .INIT_MIN(INIT_M)) dut (
        .CLK_50M   (CLK_50M),
        .CLR       (CLR),
        .CLK_1HzIn (CLK_1HzIn),
        .MODE_Key  (MODE_Key),
        .INC_Key   (INC_Key),
        .Sec_L     (Sec_L),
        .Sec_H     (Sec_H),
        .Min_L     (Min_L),
        .Min_H     (Min_H),
        .Hour_L    (Hour_L),
        .Hour_H    (Hour_H),
        .Mode_State(Mode_State),
        .Sec_Tick  (Sec_Tick),
        .Day_Carry (Day_Carry),
        .PM        (PM)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_time();
        int h, m, s, dh;
        h = m_secs / 3600;
        m = (m_secs / 60) % 60;
        s = m_secs % 60;
`ifdef TIME_COUNTER_HOUR12_EN
        dh = (h % 12 == 0) ? 12 : h % 12;
`else
        dh = h;
`endif
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic exp_pm();
`ifdef TIME_COUNTER_HOUR12_EN
        return (m_secs >= 12 * 3600);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        check("time", {Hour_H, Hour_L, Min_H, Min_L, Sec_H, Sec_L}, exp_time());
        check("mode", Mode_State, m_mode);
        check("sec_tick", Sec_Tick, e_tick);
        check("day_carry", Day_Carry, e_dc);
        check("pm", PM, exp_pm());
    endtask

    task automatic model_reset();
        m_secs  = INIT_H * 3600 + INIT_M * 60;
        m_mode  = 0;
        m_armed = 0;
        e_tick  = 0;
        e_dc    = 0;
    endtask

    task automatic model_step();
        bit te, me, ie;
        int h, m, s;
        te = m_armed && CLK_1HzIn && !m_prev_hz;
        me = m_armed && MODE_Key  && !m_prev_mk;
        ie = m_armed && INC_Key   && !m_prev_ik;
        m_prev_hz = CLK_1HzIn;
        m_prev_mk = MODE_Key;
        m_prev_ik = INC_Key;
        m_armed   = 1;
        e_tick = 0;
        e_dc   = 0;
        if (m_mode == 0 && te) begin
            m_secs = (m_secs + 1) % 86400;
            e_tick = 1;
            e_dc   = (m_secs == 0);
        end
        if (me) begin
            if (m_mode == 2) m_secs = m_secs - (m_secs % 60);
            m_mode = (m_mode + 1) % 3;
        end else if (ie) begin
            h = m_secs / 3600;
            m = (m_secs / 60) % 60;
            s = m_secs % 60;
            if (m_mode == 1) h = (h + 1) % 24;
            if (m_mode == 2) m = (m + 1) % 60;
            m_secs = h * 3600 + m * 60 + s;
        end
    endtask

    task automatic cycle(input logic hz, input logic mk, input logic ik);
        CLK_1HzIn = hz;
        MODE_Key  = mk;
        INC_Key   = ik;
        @(posedge CLK_50M);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        CLR = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge CLK_50M);
        #1;
        CLR = 1'b0;
    endtask

    task automatic hz_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_mode();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int  tick_cnt;
        logic hz, mk, ik;
        CLK_1HzIn = 1'b0;
        MODE_Key  = 1'b0;
        INC_Key   = 1'b0;
        apply_reset();
        cycle(1'b0, 1'b0, 1'b0);

        // Up to 23:59:58, then across midnight.
        hz_pulses(58);
        hz_pulses(2);

        // A long high level on the 1 Hz input is a single tick.
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tick_cnt += int'(Sec_Tick);
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("held_hz_ticks", tick_cnt, 1);

        // Setting: hours wrap without carry, minutes wrap without carry, exit clears seconds.
        press_mode();
        press_inc(25);
        press_mode();
        press_inc(61);
        press_mode();

        // MODE and INC together, then ticks while setting.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        hz_pulses(3);
        press_inc(10);
        press_mode();
        press_inc(58);
        press_mode();
        hz_pulses(60);

        // Reset in SET_MIN with the 1 Hz input held high.
        press_mode();
        press_mode();
        cycle(1'b1, 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Random phase.
        hz = CLK_1HzIn;
        mk = 1'b0;
        ik = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) hz = ~hz;
            if ($urandom_range(0, 19) == 0) mk = ~mk;
            if ($urandom_range(0, 3) == 0) ik = ~ik;
            if ($urandom_range(0, 699) == 0) begin
                CLK_1HzIn = hz;
                apply_reset();
            end else begin
                cycle(hz, mk, ik);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
